// File: rtl/coin_anim_ctrl.sv
// Coin sprite animation/placement controller: steps through the sheet frames,
// drives the sheet ROM address from the beam and registers the masked pixel.
//
// state  | meaning
// HIDDEN | coin not drawn, new-frame events ignored
// SPIN   | coin drawn, frame advances every TICKS_PER_FRAME video frames
// FLASH  | pick-up: frame advances every video frame, coin blinks, then hides
module coin_anim_ctrl #(
   parameter int         SPRITE_W        = 16,
   parameter int         SPRITE_H        = 16,
   parameter int         NUM_FRAMES      = 8,
   parameter int         SHEET_W         = 128,
   parameter int         TICKS_PER_FRAME = 6,
   parameter int         FLASH_FRAMES    = 16,
   parameter logic [7:0] TRANSPARENT_IDX = 8'h00
) (
   input  logic                          vga_clk,
   input  logic                          Reset,
   input  logic [9:0]                    DrawX,
   input  logic [9:0]                    DrawY,
   input  logic                          vs,
   input  logic                          load,
   input  logic [9:0]                    coin_x,
   input  logic [9:0]                    coin_y,
   input  logic                          collected,
   output logic [10:0]                   rom_address,
   input  logic [7:0]                    rom_q,
   output logic                          pixel_on,
   output logic [7:0]                    pixel_idx,
   output logic [$clog2(NUM_FRAMES)-1:0] anim_frame,
   output logic                          active,
   output logic                          done
);

   localparam int FRAME_W = $clog2(NUM_FRAMES);
   localparam int TICK_W  = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
   localparam int FLASH_W = (FLASH_FRAMES > 4) ? $clog2(FLASH_FRAMES) : 2;

   typedef enum logic [1:0] {HIDDEN, SPIN, FLASH} state_t;

   state_t             state, state_n;
   logic [9:0]         px, py, px_n, py_n;
   logic [TICK_W-1:0]  tick, tick_n;
   logic [FRAME_W-1:0] frame, frame_n;
   logic [FLASH_W-1:0] flash_cnt, flash_n;
   logic               vs_q, nf, done_n;
   logic [10:0]        x_lo, y_lo, dx, dy;
   logic               hit, vis, pixel_next;

   assign nf = vs_q & ~vs;

   always_comb begin
      state_n = state;
      px_n    = px;
      py_n    = py;
      tick_n  = tick;
      frame_n = frame;
      flash_n = flash_cnt;
      done_n  = 1'b0;
      if (load) begin
         state_n = SPIN;
         px_n    = coin_x;
         py_n    = coin_y;
         tick_n  = '0;
         frame_n = '0;
         flash_n = '0;
      end else begin
         case (state)
            SPIN: begin
               if (collected) begin
                  state_n = FLASH;
                  flash_n = '0;
               end else if (nf) begin
                  if (tick == TICK_W'(TICKS_PER_FRAME - 1)) begin
                     tick_n  = '0;
                     frame_n = frame + 1'b1;
                  end else begin
                     tick_n = tick + 1'b1;
                  end
               end
            end
            FLASH: begin
               if (nf) begin
                  frame_n = frame + 1'b1;
                  flash_n = flash_cnt + 1'b1;
                  if (flash_cnt == FLASH_W'(FLASH_FRAMES - 1)) begin
                     state_n = HIDDEN;
                     done_n  = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // 11-bit compares keep a coin near the right/bottom edge from wrapping to 0
   assign x_lo = {1'b0, px};
   assign y_lo = {1'b0, py};
   assign dx   = {1'b0, DrawX} - x_lo;
   assign dy   = {1'b0, DrawY} - y_lo;
   assign hit  = active
               & ({1'b0, DrawX} >= x_lo) & ({1'b0, DrawX} < x_lo + 11'(SPRITE_W))
               & ({1'b0, DrawY} >= y_lo) & ({1'b0, DrawY} < y_lo + 11'(SPRITE_H));

   assign rom_address = hit ? (11'(frame * SPRITE_W) + dx + 11'(dy * SHEET_W)) : 11'd0;

   assign vis        = (state == SPIN) | ((state == FLASH) & ~flash_cnt[1]);
   assign pixel_next = hit & vis & (rom_q != TRANSPARENT_IDX);

   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         state     <= HIDDEN;
         px        <= '0;
         py        <= '0;
         tick      <= '0;
         frame     <= '0;
         flash_cnt <= '0;
         vs_q      <= 1'b1;
         done      <= 1'b0;
         pixel_on  <= 1'b0;
         pixel_idx <= 8'h00;
      end else begin
         state     <= state_n;
         px        <= px_n;
         py        <= py_n;
         tick      <= tick_n;
         frame     <= frame_n;
         flash_cnt <= flash_n;
         vs_q      <= vs;
         done      <= done_n;
         pixel_on  <= pixel_next;
         pixel_idx <= pixel_next ? rom_q : 8'h00;
      end
   end

   assign anim_frame = frame;
   assign active     = (state != HIDDEN);

endmodule

// File: tb/tb_coin_anim_ctrl.sv
// Scoreboard bench for coin_anim_ctrl: the driver queues expected values tagged
// with the cycle they apply to; a negedge monitor pops and compares them.
module tb_coin_anim_ctrl;

   localparam int K_ADDR = 0, K_ON = 1, K_IDX = 2, K_FRAME = 3, K_ACT = 4, K_DONE = 5;

   typedef struct {
      int    at;
      int    kind;
      int    val;
      string nm;
   } exp_t;

   logic       vga_clk, Reset, vs, load, collected;
   logic [9:0] DrawX, DrawY, coin_x, coin_y;
   logic [10:0] rom_address;
   logic [7:0] rom_q, pixel_idx;
   logic       pixel_on, active, done;
   logic [2:0] anim_frame;

   exp_t sb[$];
   exp_t e;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   act_v;

   coin_anim_ctrl dut (
      .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .vs(vs),
      .load(load), .coin_x(coin_x), .coin_y(coin_y), .collected(collected),
      .rom_address(rom_address), .rom_q(rom_q), .pixel_on(pixel_on),
      .pixel_idx(pixel_idx), .anim_frame(anim_frame), .active(active), .done(done)
   );

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   always @(posedge vga_clk) cyc <= cyc + 1;

   function automatic int actual(int k);
      case (k)
         K_ADDR:  return int'(rom_address);
         K_ON:    return int'(pixel_on);
         K_IDX:   return int'(pixel_idx);
         K_FRAME: return int'(anim_frame);
         K_ACT:   return int'(active);
         default: return int'(done);
      endcase
   endfunction

   always @(negedge vga_clk) begin
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         e = sb.pop_front();
         n_checks++;
         if (e.at < cyc) begin
            n_fail++;
            $display("FAIL %s: check for cycle %0d missed (now %0d), expected %0d", e.nm, e.at, cyc, e.val);
         end else begin
            act_v = actual(e.kind);
            if (act_v != e.val) begin
               n_fail++;
               $display("FAIL %s at cycle %0d: got %0d, expected %0d", e.nm, cyc, act_v, e.val);
            end
         end
      end
   end

   task automatic step();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic expect_at(int dly, int kind, int val, string nm);
      exp_t x;
      x.at = cyc + dly; x.kind = kind; x.val = val; x.nm = nm;
      sb.push_back(x);
   endtask

   task automatic pulse_vs();
      vs = 1'b0;
      step();
      vs = 1'b1;
      step();
   endtask

   task automatic beam(int x, int y, int q);
      DrawX = 10'(x);
      DrawY = 10'(y);
      rom_q = 8'(q);
   endtask

   task automatic do_load(int x, int y);
      load = 1'b1; coin_x = 10'(x); coin_y = 10'(y);
      step();
      load = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; vs = 1'b1; load = 1'b0; collected = 1'b0;
      coin_x = '0; coin_y = '0;
      beam(5, 5, 8'h55);
      step(); step();
      Reset = 1'b0;
      expect_at(0, K_DONE, 0, "reset_done");
      expect_at(0, K_IDX, 0, "reset_pixel_idx");

      // idle two short video frames with the beam inside the reset-position box
      for (int f = 0; f < 2; f++) begin
         for (int c = 0; c < 6; c++) begin
            vs = (c == 0) ? 1'b0 : 1'b1;
            expect_at(0, K_ADDR, 0, "idle_addr");
            expect_at(0, K_ON, 0, "idle_pixel_on");
            expect_at(0, K_ACT, 0, "idle_active");
            expect_at(0, K_FRAME, 0, "idle_frame");
            step();
         end
      end

      // basic placement and transparency
      do_load(100, 200);
      expect_at(0, K_ACT, 1, "load_active");
      beam(105, 203, 8'h2A);
      expect_at(0, K_ADDR, 389, "addr_105_203");
      expect_at(1, K_ON, 1, "opaque_on");
      expect_at(1, K_IDX, 8'h2A, "opaque_idx");
      step();
      beam(105, 203, 8'h00);
      expect_at(0, K_ADDR, 389, "addr_hold");
      expect_at(1, K_ON, 0, "transparent_on");
      expect_at(1, K_IDX, 0, "transparent_idx");
      step();
      beam(115, 215, 8'h77);
      expect_at(0, K_ADDR, 1935, "addr_corner");
      expect_at(1, K_ON, 1, "corner_on");
      expect_at(1, K_IDX, 8'h77, "corner_idx");
      step();
      beam(116, 215, 8'h77);
      expect_at(0, K_ADDR, 0, "addr_right_out");
      expect_at(1, K_ON, 0, "right_out_on");
      step();
      beam(110, 216, 8'h77);
      expect_at(0, K_ADDR, 0, "addr_below_out");
      expect_at(1, K_ON, 0, "below_out_on");
      step();

      // spin: one step every 6 new-frame events, wrapping after 48
      for (int k = 1; k <= 48; k++) begin
         pulse_vs();
         expect_at(0, K_FRAME, (k / 6) % 8, "spin_frame");
         if (k == 18) begin
            beam(100, 200, 8'h10);
            expect_at(0, K_ADDR, 48, "addr_frame3");
         end
      end

      // clipping at the bottom-right screen corner
      do_load(630, 470);
      beam(639, 479, 8'h11);
      expect_at(0, K_ADDR, 1161, "clip_addr");
      expect_at(1, K_ON, 1, "clip_on");
      expect_at(1, K_IDX, 8'h11, "clip_idx");
      step();
      beam(0, 0, 8'h11);
      expect_at(0, K_ADDR, 0, "clip_origin_addr");
      expect_at(1, K_ON, 0, "clip_origin_on");
      step();
      beam(629, 470, 8'h11);
      expect_at(0, K_ADDR, 0, "clip_left_addr");
      step();

      // pick-up sequence
      beam(632, 471, 8'h33);
      collected = 1'b1;
      step();
      collected = 1'b0;
      expect_at(0, K_ACT, 1, "flash_active");
      for (int ev = 1; ev <= 16; ev++) begin
         expect_at(0, K_ADDR, 130 + 16 * ((ev - 1) % 8), "flash_addr");
         expect_at(0, K_DONE, 0, "flash_done_low");
         expect_at(1, K_ON, (((ev - 1) & 2) == 0) ? 1 : 0, "flash_blink");
         expect_at(1, K_DONE, (ev == 16) ? 1 : 0, "flash_done");
         expect_at(1, K_ACT, (ev == 16) ? 0 : 1, "flash_active_fall");
         if (ev < 16) expect_at(1, K_FRAME, ev % 8, "flash_frame");
         expect_at(2, K_DONE, 0, "done_single");
         pulse_vs();
      end
      expect_at(0, K_ADDR, 0, "hidden_addr");
      expect_at(1, K_ON, 0, "hidden_on");
      step();

      // load together with collected and a new-frame event
      do_load(100, 200);
      for (int k = 0; k < 7; k++) pulse_vs();
      expect_at(0, K_FRAME, 1, "pre_combo_frame");
      load = 1'b1; collected = 1'b1; vs = 1'b0; coin_x = 10'd100; coin_y = 10'd200;
      step();
      load = 1'b0; collected = 1'b0; vs = 1'b1;
      expect_at(0, K_ACT, 1, "combo_active");
      expect_at(0, K_FRAME, 0, "combo_frame_clear");
      step();
      for (int k = 1; k <= 6; k++) begin
         pulse_vs();
         expect_at(0, K_FRAME, (k == 6) ? 1 : 0, "combo_tick_clear");
      end

      // reset in the middle of the pick-up sequence
      collected = 1'b1;
      step();
      collected = 1'b0;
      pulse_vs();
      expect_at(0, K_ACT, 1, "pre_reset_active");
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         expect_at(0, K_ACT, 0, "reset_flash_active");
         expect_at(0, K_DONE, 0, "reset_flash_done");
         expect_at(0, K_FRAME, 0, "reset_flash_frame");
         expect_at(0, K_ON, 0, "reset_flash_on");
         step();
      end

      for (int i = 0; i < 8 && sb.size() > 0; i++) step();
      if (sb.size() > 0) begin
         $display("FAIL scoreboard_drain: %0d checks left, expected 0", sb.size());
         n_fail += sb.size();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/coin_anim_ctrl.md
# coin_anim_ctrl

Animation and placement controller for one copper-coin sprite. It sequences the 128x16 coin sprite sheet (8 frames of 16x16) across video frames and positions the sprite at a programmable screen location. It drives the sheet ROM address from the current beam position and emits a registered, transparency-masked palette index to the pixel compositor. It also runs a pick-up sequence: a fast spin with blinking, then the coin is hidden.

## Interface
Parameters:
- SPRITE_W, 16: frame width in pixels
- SPRITE_H, 16: frame height in pixels
- NUM_FRAMES, 8: frames in sheet (power of two)
- SHEET_W, 128: sheet row pitch in pixels, equal to SPRITE_W*NUM_FRAMES
- TICKS_PER_FRAME, 6: video frames per animation step while spinning (must be ≥1)
- FLASH_FRAMES, 16: video frames in the pick-up sequence
- TRANSPARENT_IDX, 8'h00: palette index treated as transparent

Ports:
- vga_clk  in  1  pixel clock; all state updates on posedge
- Reset  in  1  synchronous, active-high
- DrawX, DrawY  in  10 each  current beam position
- vs  in  1  vertical sync, active-low
- load  in  1  one-cycle pulse: latch coin_x/coin_y, start spinning
- coin_x, coin_y  in  10 each  top-left corner of sprite, sampled on load
- collected  in  1  one-cycle pulse: start the pick-up sequence
- rom_address  out  11  sheet ROM address; combinational
- rom_q  in  8  ROM data, read on negedge of vga_clk, valid before next posedge
- pixel_on  out  1  registered: sprite pixel is opaque and visible
- pixel_idx  out  8  registered palette index; 0 when pixel_on=0
- anim_frame  out  3  current sheet frame
- active  out  1  state ≠ HIDDEN
- done  out  1  one-cycle pulse when the pick-up sequence ends

## Operation
- New-frame event `nf`: falling edge of vs, detected with a registered copy vs_q (reset value 1). `nf = vs_q & ~vs`.
- States:
  - HIDDEN: sprite not drawn; `nf` ignored.
  - SPIN: sprite drawn; on `nf`, tick increments. When tick = TICKS_PER_FRAME-1, tick clears and anim_frame advances.
  - FLASH: anim_frame advances on every `nf` and flash_cnt increments. Sprite is drawn only while flash_cnt[1] = 0. On the `nf` where flash_cnt = FLASH_FRAMES-1, go to HIDDEN and pulse done in the same cycle.
- anim_frame wraps modulo NUM_FRAMES (7 → 0).
- Transitions:
  - load in any state: go to SPIN. Latch position; clear tick, anim_frame and flash_cnt.
  - collected in SPIN: go to FLASH with flash_cnt = 0. anim_frame keeps its value.
  - collected in HIDDEN or FLASH: ignored.
  - load and collected in the same cycle: load wins.
  - load coincident with `nf`: load wins; counters clear and `nf` is not applied.
- Hit test uses 11-bit unsigned compares, so there is no wrap at the right or bottom edge:
  - `hit = DrawX ≥ px && DrawX < px+SPRITE_W && DrawY ≥ py && DrawY < py+SPRITE_H`
  - A coin at x = 630 is clipped to its 10 on-screen columns.
- Address:
  - When hit: `rom_address = anim_frame*SPRITE_W + (DrawX-px) + (DrawY-py)*SHEET_W`, truncated to 11 bits.
  - When not hit: rom_address = 0.
- Visibility: `vis = (state=SPIN) | (state=FLASH & ~flash_cnt[1])`.
- Pixel register, updated every posedge:
  - `pixel_on ← hit & vis & (rom_q ≠ TRANSPARENT_IDX)`
  - `pixel_idx ← pixel_on_next ? rom_q : 0`

## Timing
- Reset values: state HIDDEN, position (0,0), tick 0, anim_frame 0, flash_cnt 0, vs_q 1. Outputs: pixel_on 0, pixel_idx 0, done 0, active 0.
- Reset mid-sequence (SPIN or FLASH) reaches HIDDEN on the next edge. No done pulse is issued.
- rom_address is combinational from DrawX/DrawY and state, with 0-cycle latency. The ROM is read on the negedge of the same cycle.
- pixel_on/pixel_idx lag DrawX/DrawY by exactly 1 vga_clk cycle. The compositor delays its own coordinates to match.
- A load at cycle t takes effect at posedge t+1, and the sprite can be drawn from cycle t+1.
- An animation step becomes visible on the cycle after `nf`. anim_frame is constant across a video frame.
- done is high for exactly 1 cycle, coincident with active falling.

## Test plan
- Reset then idle for 2 frames: pixel_on=0, rom_address=0, active=0 and anim_frame=0 throughout.
- load (100,200), then beam at (105,203) with anim_frame=0: rom_address=5+3*128=389. ROM returns 8'h2A, so the next cycle gives pixel_on=1 and pixel_idx=8'h2A. ROM returns 8'h00, so pixel_on=0.
- SPIN with TICKS_PER_FRAME=6 over 48 vs falling edges: anim_frame steps every 6 edges and wraps 7→0 at edge 48. Beam at (100,200) with frame 3 gives rom_address=48.
- Clipping: load (630,470), beam at (639,479): rom_address=9+9*128=1161 and pixel drawn. Beam at (0,0) is not hit.
- collected in SPIN, then 16 `nf` edges: frame advances each edge; sprite drawn on flash_cnt 0–1, 4–5, 8–9, 12–13. done pulses once, then HIDDEN.
- load and collected on the same cycle: state SPIN and counters cleared. Reset asserted during FLASH: HIDDEN next cycle with no done pulse.
